// File: rtl/edge_detector_multi.sv
// ============================================================================
// Module   : edge_detector_multi
// Brief    : Multi-channel async-input synchroniser, glitch filter and edge
//            detector; per-channel event counters when EDGE_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detector_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter bit RST_LEVEL     = 1'b0,
    parameter int CNT_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       async_in,
    input  logic [1:0]                edge_sel,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       rising_edge,
    output logic [CHANNELS-1:0]       falling_edge,
    output logic [CHANNELS-1:0]       event_out,
    output logic [CHANNELS*CNT_W-1:0] edge_cnt,
    output logic [CHANNELS-1:0]       cnt_sat
);

    localparam int                c_FC_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FILTER_CYCLES - 1);

    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_event;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_FC_W-1:0]      r_fc;
            logic                   r_f;
            logic                   r_f_d;
            logic                   w_s;

            assign w_s = r_sync[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= {SYNC_STAGES{RST_LEVEL}};
                    r_fc   <= '0;
                    r_f    <= RST_LEVEL;
                    r_f_d  <= RST_LEVEL;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], async_in[i]};
                    r_f_d  <= r_f;
                    // Any cycle where the synchronised level agrees restarts the filter.
                    if (w_s == r_f) begin
                        r_fc <= '0;
                    end else if (r_fc == c_FC_LAST) begin
                        r_f  <= w_s;
                        r_fc <= '0;
                    end else begin
                        r_fc <= r_fc + 1'b1;
                    end
                end
            end

            assign level[i]        = r_f;
            assign w_rise[i]       = r_f & ~r_f_d;
            assign w_fall[i]       = ~r_f & r_f_d;
            assign rising_edge[i]  = w_rise[i];
            assign falling_edge[i] = w_fall[i];

`ifdef EDGE_COUNT_EN
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_event[i] && !(&r_cnt)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign edge_cnt[i*CNT_W +: CNT_W] = r_cnt;
            assign cnt_sat[i]                 = &r_cnt;
`endif
        end
    endgenerate

`ifndef EDGE_COUNT_EN
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign edge_cnt         = '0;
    assign cnt_sat          = '0;
`endif

    always_comb begin
        w_event = '0;
        case (edge_sel)
            2'b00:   w_event = w_rise;
            2'b01:   w_event = w_fall;
            2'b10:   w_event = w_rise | w_fall;
            default: w_event = '0;
        endcase
    end

    assign event_out = w_event;

endmodule

`default_nettype wire

// File: doc/edge_detector_multi.md
# edge_detector_multi

Multi-channel, parametrised successor to the single-bit asynchronous edge detector. Each of `CHANNELS` asynchronous inputs is brought into the `clk` domain through a configurable synchroniser chain, passed through a consecutive-cycle glitch filter, and reduced to single-cycle rising, falling and mode-selected event pulses. Optional per-channel saturating event counters are included. The block sits between receiver front-end comparator/trigger lines and the capture/control logic.

## Interface
- `CHANNELS`, 4: number of independent input channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (2..4).
- `FILTER_CYCLES`, 1: consecutive cycles the synchronised level must differ before it is accepted (1..255); 1 means no filtering.
- `RST_LEVEL`, 0: reset value of every sync stage and the filtered level.
- `CNT_W`, 16: width of each event counter (4..32).

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `async_in`  in  CHANNELS  asynchronous inputs.
- `edge_sel`  in  2  event mode, shared by all channels: 00 rising, 01 falling, 10 both, 11 none.
- `cnt_clr`  in  1  synchronous clear of all event counters.
- `level`  out  CHANNELS  filtered level.
- `rising_edge`  out  CHANNELS  one-cycle pulse on filtered 0→1.
- `falling_edge`  out  CHANNELS  one-cycle pulse on filtered 1→0.
- `event_out`  out  CHANNELS  `rising_edge`/`falling_edge` gated by `edge_sel`.
- `edge_cnt`  out  CHANNELS*CNT_W  counters; channel i occupies bits [i*CNT_W +: CNT_W].
- `cnt_sat`  out  CHANNELS  counter i is at all-ones.

## Operation
- Per channel: sync chain q[1..SYNC_STAGES]; `s` = q[SYNC_STAGES]; filtered level `f`; previous level `f_d`; filter counter `fc` of width clog2(FILTER_CYCLES+1).
- Filter, each cycle: if `s == f`, `fc <= 0`. Otherwise, if `fc == FILTER_CYCLES-1`, then `f <= s` and `fc <= 0`; else `fc <= fc+1`.
- A pulse at `s` shorter than FILTER_CYCLES cycles produces no change to `f` and no edge. `fc` returns to 0 on the first cycle where `s == f`.
- `f_d <= f` every cycle. `rising_edge = f & ~f_d`. `falling_edge = ~f & f_d`. All three are decoded combinationally from registers.
- `level = f`.
- `event_out` is `rising_edge` (00), `falling_edge` (01), their OR (10), or 0 (11). `edge_sel` takes effect in the same cycle it changes.
- Counter: if `cnt_clr`, counter <= 0; clear wins over a simultaneous event. Otherwise, on `event_out[i]`, counter increments and saturates at 2^CNT_W−1. `cnt_sat[i]` is high while the counter is at all-ones.
- Channels are fully independent. Simultaneous events on several channels are all counted.

## Timing
- Reset (`rst_n` low, asynchronous): q, `f`, `f_d` = RST_LEVEL; `fc` = 0; counters = 0.
- Outputs during reset: `level` = RST_LEVEL; `rising_edge`, `falling_edge`, `event_out`, `cnt_sat` = 0; `edge_cnt` = 0.
- Leaving reset with `async_in` == RST_LEVEL produces no edge. Leaving reset with `async_in` != RST_LEVEL produces exactly one edge after full latency.
- Reset asserted mid-filter aborts the pending transition; no edge is emitted.
- Latency: let the first clk edge that samples a new, stable `async_in` value be edge 1. `f` changes at edge SYNC_STAGES+FILTER_CYCLES. The edge pulse is high for exactly the following cycle, and the counter updates at the next edge.
- Minimum accepted pulse width at `s`: FILTER_CYCLES cycles. Minimum spacing between consecutive same-direction edges: 2·FILTER_CYCLES cycles.

## Configuration
- `EDGE_COUNT_EN` defined: event counters, `cnt_clr`, `edge_cnt` and `cnt_sat` behave as above.
- `EDGE_COUNT_EN` undefined: no counter logic. `edge_cnt` and `cnt_sat` are tied to 0, and `cnt_clr` is ignored. Ports remain present.

## Test plan
- Defaults, ch0 0→1 held: `rising_edge[0]` is high for exactly one cycle, in the cycle after edge 3; `level[0]` = 1 from edge 3; no pulse on other channels.
- FILTER_CYCLES=4, 3-cycle high glitch on ch1: no edge and `level[1]` stays 0. A following 4-cycle high produces one rising edge, then one falling edge when the input drops.
- `edge_sel` = 10 and ch2 toggled 5 full periods: `edge_cnt[2]` = 10. `edge_sel` = 11 with the same stimulus: count unchanged.
- CNT_W=4, `edge_sel` = 00, 20 rising edges on ch3: count stops at 15 and `cnt_sat[3]` = 1. `cnt_clr` coincident with an edge leaves the count at 0.
- RST_LEVEL=1 with `async_in` = 1 through reset release: no edges. Assert `rst_n` during a pending FILTER_CYCLES=8 transition: outputs at reset values and no edge after release while the input is stable at 1.
- Build without `EDGE_COUNT_EN`: pulses identical to the defaults case; `edge_cnt` and `cnt_sat` are constantly 0.
